// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: bubble encoding, PC increment and fetch FSM states.
package fetch_pkg;

  localparam logic [31:0] BUBBLE_INSTR = 32'd0;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef enum logic [1:0] {
    FETCH,
    DRAIN,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {instr, addr} parking register for a word that lands while decode is stalled.
// Loads on the accept edge, readable the next cycle; clear wins over load.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_addr,
  output logic [31:0] instr,
  output logic [31:0] addr
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr <= '0;
      addr  <= '0;
    end else if (clear) begin
      instr <= '0;
      addr  <= '0;
    end else if (load) begin
      instr <= load_instr;
      addr  <= load_addr;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, requests imem over req/ready and registers {instruction, instr_address} one cycle after accept.
// Stall holds outputs (late words park in a hold buffer); redirects flush and drain any in-flight request.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] instr_address,
  output logic        flush
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  redirect_pc;
  logic         pending;
  logic         accept;
  logic [31:0]  target;
  logic         buf_load;
  logic         buf_clear;
  logic [31:0]  buf_instr;
  logic [31:0]  buf_addr;

  assign target    = redirect_target & ~32'h3;
  assign flush     = redirect;
  assign imem_addr = pc;
  // Once raised, a request stays up until accepted, even across a new stall.
  assign imem_req  = !reset && (((state == FETCH) && (pending || !stall)) || (state == DRAIN));
  assign accept    = imem_req && imem_ready;
  assign buf_load  = (state == FETCH) && !redirect && accept && stall;
  assign buf_clear = (state == HOLD) && (redirect || !stall);

  fetch_hold_buf u_hold_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_instr (imem_rdata),
    .load_addr  (pc),
    .instr      (buf_instr),
    .addr       (buf_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      redirect_pc   <= '0;
      pending       <= 1'b0;
      instruction   <= BUBBLE_INSTR;
      instr_address <= '0;
    end else begin
      pending <= imem_req && !imem_ready;
      case (state)
        FETCH: begin
          if (redirect) begin
            instruction   <= BUBBLE_INSTR;
            instr_address <= '0;
            // An in-flight request must complete before the target can be issued.
            if (pending && !imem_ready) begin
              redirect_pc <= target;
              state       <= DRAIN;
            end else begin
              pc <= target;
            end
          end else if (accept) begin
            pc <= pc + PC_STEP;
            if (stall) begin
              state <= HOLD;
            end else begin
              instruction   <= imem_rdata;
              instr_address <= pc;
            end
          end else if (!stall) begin
            instruction   <= BUBBLE_INSTR;
            instr_address <= '0;
          end
        end
        DRAIN: begin
          instruction   <= BUBBLE_INSTR;
          instr_address <= '0;
          if (redirect) redirect_pc <= target;
          if (accept) begin
            pc    <= redirect ? target : redirect_pc;
            state <= FETCH;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc            <= target;
            instruction   <= BUBBLE_INSTR;
            instr_address <= '0;
            state         <= FETCH;
          end else if (!stall) begin
            instruction   <= buf_instr;
            instr_address <= buf_addr;
            state         <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized wait/stall run against a queue-based model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] instr_address;
  logic        flush;

  int checks = 0;
  int errors = 0;
  int mem_wait = 0;
  int mem_cnt = 0;
  logic        snap_req, snap_rdy;
  logic [31:0] snap_addr, snap_data;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .instruction     (instruction),
    .instr_address   (instr_address),
    .flush           (flush)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h0000_A5A5;
  endfunction

  // Memory answers after mem_wait non-ready request cycles; data is a function of the address.
  task automatic settle();
    #1;
    imem_ready = imem_req && (mem_cnt >= mem_wait);
    imem_rdata = imem_ready ? word_at(imem_addr) : 32'hDEAD_BEEF;
    #1;
    snap_req  = imem_req;
    snap_rdy  = imem_ready;
    snap_addr = imem_addr;
    snap_data = imem_rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (snap_req && snap_rdy) mem_cnt = 0;
    else if (snap_req) mem_cnt++;
  endtask

  task automatic apply_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
    imem_ready = 1'b0; imem_rdata = '0; mem_cnt = 0; mem_wait = 0;
    snap_req = 1'b0; snap_rdy = 1'b0; snap_addr = '0; snap_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
    imem_ready = 1'b0; imem_rdata = '0; mem_cnt = 0; mem_wait = 0;
    #3;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %h exp 0", imem_req); end
    checks++; if ({instruction, instr_address} !== 64'd0) begin errors++; $display("FAIL reset_out got %h/%h exp 0/0", instruction, instr_address); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %h exp 0", flush); end
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    settle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL first_req got %h@%h exp 1@00000100", imem_req, imem_addr); end
    tick();
  endtask

  task automatic test_zero_wait();
    logic [31:0] a;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      a = 32'h100 + 32'(4 * i);
      settle();
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL zw_flush got %h exp 0", flush); end
      tick();
      checks++; if (instr_address !== a || instruction !== word_at(a)) begin errors++; $display("FAIL zw_out%0d got %h/%h exp %h/%h", i, instr_address, instruction, a, word_at(a)); end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] a;
    apply_reset();
    mem_wait = 2;
    for (int k = 0; k < 2; k++) begin
      a = 32'h100 + 32'(4 * k);
      for (int w = 0; w < 3; w++) begin
        settle();
        checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin errors++; $display("FAIL ws_addr got %h@%h exp 1@%h", imem_req, imem_addr, a); end
        tick();
        if (w == 2) begin
          checks++; if (instr_address !== a || instruction !== word_at(a)) begin errors++; $display("FAIL ws_out got %h/%h exp %h/%h", instr_address, instruction, a, word_at(a)); end
        end else begin
          checks++; if ({instruction, instr_address} !== 64'd0) begin errors++; $display("FAIL ws_bubble got %h/%h exp 0/0", instruction, instr_address); end
        end
      end
    end
  endtask

  task automatic test_redirect_pending();
    apply_reset();
    repeat (3) begin settle(); tick(); end
    mem_wait = 3;
    settle(); tick();
    redirect = 1'b1; redirect_target = 32'h0000_0203;
    settle();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rp_flush got %h exp 1", flush); end
    checks++; if (imem_addr !== 32'h10C) begin errors++; $display("FAIL rp_hold_addr got %h exp 0000010c", imem_addr); end
    tick();
    redirect = 1'b0;
    checks++; if ({instruction, instr_address} !== 64'd0) begin errors++; $display("FAIL rp_bubble got %h/%h exp 0/0", instruction, instr_address); end
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10C) begin errors++; $display("FAIL rp_drain got %h@%h exp 1@0000010c", imem_req, imem_addr); end
      tick();
      checks++; if ({instruction, instr_address} !== 64'd0) begin errors++; $display("FAIL rp_stale got %h/%h exp 0/0", instruction, instr_address); end
    end
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rp_target got %h@%h exp 1@00000200", imem_req, imem_addr); end
      tick();
      if (c == 3) begin
        checks++; if (instr_address !== 32'h200 || instruction !== word_at(32'h200)) begin errors++; $display("FAIL rp_out got %h/%h exp 00000200/%h", instr_address, instruction, word_at(32'h200)); end
      end else begin
        checks++; if ({instruction, instr_address} !== 64'd0) begin errors++; $display("FAIL rp_wait got %h/%h exp 0/0", instruction, instr_address); end
      end
    end
  endtask

  task automatic test_stall_hold();
    apply_reset();
    settle(); tick();
    stall = 1'b1;
    settle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL sh_noreq got %h exp 0", imem_req); end
    tick();
    checks++; if (instr_address !== 32'h100 || instruction !== word_at(32'h100)) begin errors++; $display("FAIL sh_hold got %h/%h exp 00000100/%h", instr_address, instruction, word_at(32'h100)); end
    mem_wait = 2; stall = 1'b0;
    settle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin errors++; $display("FAIL sh_req got %h@%h exp 1@00000104", imem_req, imem_addr); end
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (imem_req !== (i < 2)) begin errors++; $display("FAIL sh_req_stall%0d got %h exp %h", i, imem_req, (i < 2)); end
      tick();
      checks++; if ({instruction, instr_address} !== 64'd0) begin errors++; $display("FAIL sh_held%0d got %h/%h exp 0/0", i, instruction, instr_address); end
    end
    stall = 1'b0;
    settle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL sh_release_req got %h exp 0", imem_req); end
    tick();
    checks++; if (instr_address !== 32'h104 || instruction !== word_at(32'h104)) begin errors++; $display("FAIL sh_release got %h/%h exp 00000104/%h", instr_address, instruction, word_at(32'h104)); end
    settle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin errors++; $display("FAIL sh_next got %h@%h exp 1@00000108", imem_req, imem_addr); end
    tick();
    checks++; if ({instruction, instr_address} !== 64'd0) begin errors++; $display("FAIL sh_dup got %h/%h exp 0/0", instruction, instr_address); end
  endtask

  task automatic test_redirect_hold();
    apply_reset();
    mem_wait = 1;
    repeat (3) begin settle(); tick(); end
    stall = 1'b1;
    settle(); tick();
    redirect = 1'b1; redirect_target = 32'h0000_0300;
    settle();
    checks++; if (flush !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL rh_flush got flush %h req %h exp 1 0", flush, imem_req); end
    tick();
    checks++; if ({instruction, instr_address} !== 64'd0) begin errors++; $display("FAIL rh_bubble got %h/%h exp 0/0", instruction, instr_address); end
    redirect = 1'b0; stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL rh_target got %h@%h exp 1@00000300", imem_req, imem_addr); end
      tick();
      if (i == 1) begin
        checks++; if (instr_address !== 32'h300 || instruction !== word_at(32'h300)) begin errors++; $display("FAIL rh_out got %h/%h exp 00000300/%h", instr_address, instruction, word_at(32'h300)); end
      end else begin
        checks++; if ({instruction, instr_address} !== 64'd0) begin errors++; $display("FAIL rh_drop got %h/%h exp 0/0", instruction, instr_address); end
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
    settle(); tick();
    redirect = 1'b0;
    checks++; if ({instruction, instr_address} !== 64'd0) begin errors++; $display("FAIL wr_discard got %h/%h exp 0/0", instruction, instr_address); end
    settle();
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_addr got %h exp fffffffc", imem_addr); end
    tick();
    checks++; if (instr_address !== 32'hFFFF_FFFC || instruction !== word_at(32'hFFFF_FFFC)) begin errors++; $display("FAIL wr_out got %h/%h exp fffffffc/%h", instr_address, instruction, word_at(32'hFFFF_FFFC)); end
    settle();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wr_wrap got %h exp 00000000", imem_addr); end
    tick();
    checks++; if (instr_address !== 32'h0 || instruction !== 32'h0000_A5A5) begin errors++; $display("FAIL wr_out0 got %h/%h exp 00000000/0000a5a5", instr_address, instruction); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    settle(); tick();
    mem_wait = 3;
    settle();
    reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || {instruction, instr_address} !== 64'd0) begin errors++; $display("FAIL ar_clear got req %h out %h/%h exp 0 0/0", imem_req, instruction, instr_address); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; mem_cnt = 0; mem_wait = 0;
    settle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL ar_pc got %h@%h exp 1@00000100", imem_req, imem_addr); end
    tick();
    checks++; if (instr_address !== 32'h100 || instruction !== word_at(32'h100)) begin errors++; $display("FAIL ar_out got %h/%h exp 00000100/%h", instr_address, instruction, word_at(32'h100)); end
  endtask

  // Model: accepted words enter a queue in program order; every unstalled edge delivers the head or a bubble,
  // every stalled edge leaves the outputs untouched.
  task automatic test_random();
    logic [31:0] model_pc;
    logic [63:0] q[$];
    logic [63:0] exp_out;
    logic [63:0] prev;
    logic        p_req, p_rdy, st;
    logic [31:0] p_addr;
    apply_reset();
    model_pc = 32'h100; mem_wait = $urandom_range(0, 3);
    p_req = 1'b0; p_rdy = 1'b0; p_addr = '0; prev = 64'd0;
    for (int c = 0; c < 500; c++) begin
      st = (c < 480) && ($urandom_range(0, 3) == 0);
      stall = st;
      settle();
      if (p_req && !p_rdy) begin
        checks++; if (imem_req !== 1'b1 || imem_addr !== p_addr) begin errors++; $display("FAIL rnd_stable c%0d got %h@%h exp 1@%h", c, imem_req, imem_addr, p_addr); end
      end
      if (snap_req && snap_rdy) begin
        checks++; if (snap_addr !== model_pc) begin errors++; $display("FAIL rnd_seq c%0d got %h exp %h", c, snap_addr, model_pc); end
        q.push_back({word_at(model_pc), model_pc});
        model_pc += 32'd4;
      end
      p_req = snap_req; p_rdy = snap_rdy; p_addr = snap_addr;
      tick();
      if (p_req && p_rdy) mem_wait = $urandom_range(0, 3);
      if (!st) exp_out = (q.size() > 0) ? q.pop_front() : 64'd0;
      else exp_out = prev;
      checks++; if ({instruction, instr_address} !== exp_out) begin errors++; $display("FAIL rnd_out c%0d got %h/%h exp %h/%h", c, instruction, instr_address, exp_out[63:32], exp_out[31:0]); end
      prev = exp_out;
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_lost got %0d exp 0", q.size()); end
    stall = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_redirect_pending();
    test_stall_hold();
    test_redirect_hold();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the 5-stage RV32 pipeline: owns the PC, issues requests to instruction memory over a req/ready handshake, and drives the fetch side of the IF/ID pipeline register. Produces `instruction`/`instr_address` pairs and the `flush` strobe that the IF/ID register consumes. Handles EX-stage redirects (taken branch/jump), decode stalls and variable-latency memory responses. Wrong-path or unready cycles are emitted as bubbles.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `stall`  in  1  decode hazard; hold outputs, do not advance.
- `redirect`  in  1  taken branch/jump from EX; highest priority.
- `redirect_target`  in  32  new PC; bits [1:0] forced to 0.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address; stable while `imem_req && !imem_ready`.
- `imem_ready`  in  1  response strobe; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  32  fetched word.
- `instruction`  out  32  to IF/ID; 32'd0 = bubble.
- `instr_address`  out  32  to IF/ID; PC of `instruction`, 0 for bubble.
- `flush`  out  1  to IF/ID; equals `redirect` combinationally.

## Operation
- Registers: `pc`, `redirect_pc`, `pending`, `state`, hold buffer (`buf_instr`, `buf_addr`), output registers.
- Accept: `imem_req && imem_ready`. `pending` is set on `imem_req && !imem_ready`, cleared on accept.
- `imem_req` = (FETCH && (pending || !stall)) || DRAIN. Zero in HOLD. A raised request is never withdrawn before accept. `imem_addr` = `pc`.
- States and transitions (`redirect` is evaluated first in every state):
- FETCH, redirect: if pending && !imem_ready -> `redirect_pc`<=target, DRAIN. Else `pc`<=target, stay FETCH, discard any same-cycle response. Outputs <= bubble.
- FETCH, accept && !stall: outputs <= {rdata, pc}, `pc`<=pc+4.
- FETCH, accept && stall: buffer <= {rdata, pc}, `pc`<=pc+4, -> HOLD. Outputs hold.
- FETCH, no accept: outputs <= bubble if !stall; hold if stall.
- DRAIN: outputs <= bubble. A repeated redirect overwrites `redirect_pc`. On accept: discard data, `pc`<=`redirect_pc`, -> FETCH.
- HOLD, !stall: outputs <= buffer, -> FETCH. With stall: hold everything. With redirect: drop buffer, `pc`<=target, outputs <= bubble, -> FETCH.
- Arithmetic: `pc`+4 wraps modulo 2^32. No misalignment traps.

## Timing
- Reset (async): `pc`=RESET_PC, state FETCH, `pending`=0. `instruction`, `instr_address`, buffer = 0. `imem_req` = 0 while `reset` is high.
- First `imem_req` is in the first cycle after reset deasserts.
- Zero-wait memory (ready in the request cycle): one instruction per cycle. `instruction` appears 1 cycle after accept.
- N wait cycles: N bubbles between instructions.
- Redirect in cycle t: `flush`=1 in t. IF/ID and the fetch outputs are bubble from t+1.
  - No pending request: target is requested in t+1.
  - Pending request: target is requested the cycle after the stale response.
- Stall release from HOLD: buffered instruction appears at the next edge. No instruction is lost or duplicated.
- Reset mid-request: request abandoned. The memory model must tolerate a dropped request.

## Structure
- Shared package `fetch_pkg`:
  - `BUBBLE_INSTR` = 32'd0, matching the IF/ID flush value.
  - `PC_STEP` = 4.
  - `fetch_state_t` enum: FETCH, DRAIN, HOLD.
- One sub-module, `fetch_hold_buf`: a 1-entry {instr, addr} register with load/clear.
- All other logic is in `instr_fetch_unit`. Target size: ~150–250 lines.

## Test plan
- Reset, RESET_PC=0x100, zero-wait memory returning addr^0xA5A5 -> outputs (0x100, …), (0x104, …), (0x108, …) on consecutive cycles. `flush`=0.
- Memory with 2 wait cycles -> two bubbles (instruction=0, instr_address=0) between fetches. `imem_addr` stable while pending.
- Redirect to 0x200 while a request to 0x10C is pending -> `flush` pulse. The stale 0x10C word never reaches outputs. Next accepted address is 0x200.
- Response arrives during 3-cycle stall -> outputs hold the previous instruction, `imem_req`=0. After release, the buffered word appears exactly once, then the next request goes to pc+4.
- Redirect while in HOLD -> buffered word dropped, `flush`=1, next request goes to the target.
- `pc` at 0xFFFF_FFFC -> next fetch at 0x0000_0000. Async reset asserted mid-request -> all outputs 0 immediately and `pc`=RESET_PC.
